// File: rtl/pattern_generator.sv
// ---------------------------------------------------------------------------
// pattern_generator
//   Serial bit-pattern transmitter. A parallel pattern is latched on start and
//   shifted out MSB-first (bit [len-1] first) on x, qualified by valid. The
//   pattern is sent repeat_cnt+1 times with a single idle gap cycle between
//   sends. The sink throttles the stream with ready; a bit is consumed at a
//   posedge where ready and valid are both high.
//
//   Optional feature macro: PATGEN_PRBS_EN
//     Adds prbs_sel. When latched high, bits come from a PRBS7 LFSR
//     (x^7+x^6+1, seed 7'h7F, output = register MSB) instead of the pattern.
//
// Parameters
//   W   pattern width in bits (>=2)
//   LW  width of len, must satisfy 2**LW > W
//   RW  width of repeat_cnt
//
// Ports
//   clk         in   clock, posedge
//   n_rst       in   asynchronous active-low reset
//   start       in   begin a transmission (only honoured when idle)
//   pattern     in   [W]  bits to send
//   len         in   [LW] bits per pattern, 0 or >W means W
//   repeat_cnt  in   [RW] extra repeats
//   prbs_sel    in   select PRBS7 source (only with PATGEN_PRBS_EN)
//   ready       in   sink accepts the current bit
//   x           out  serial data (registered)
//   valid       out  x carries a pattern bit (registered)
//   busy        out  transmission in progress, through the done cycle
//   done        out  one-cycle pulse after the final bit
// ---------------------------------------------------------------------------
module pattern_generator #(
    parameter int W  = 8,
    parameter int LW = 4,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] len,
    input  logic [RW-1:0] repeat_cnt,
`ifdef PATGEN_PRBS_EN
    input  logic          prbs_sel,
`endif
    input  logic          ready,
    output logic          x,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    localparam logic [LW-1:0] W_L = LW'(W);

    state_t        state, state_next;
    logic [W-1:0]  pat_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] len_norm;
    logic [LW-1:0] bit_idx, bit_idx_next;
    logic [RW-1:0] reps_left, reps_next;
    logic [W-1:0]  pat_shift;
    logic          x_next, valid_next, busy_next, done_next;

`ifdef PATGEN_PRBS_EN
    logic          prbs_q;
    logic          prbs_active;
    logic [6:0]    lfsr, lfsr_next;
`endif

    // Out-of-range lengths fall back to the full pattern width.
    assign len_norm = (len == '0 || len > W_L) ? W_L : len;

    // State register; reset aborts any transmission without a done pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A stalled SHIFT (ready low) simply stays put; the
    // last accepted bit of a pass decides between another pass and DONE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = SHIFT;
            SHIFT: begin
                if (ready && bit_idx == '0) begin
                    state_next = (reps_left != '0) ? GAP : DONE;
                end
            end
            GAP:   state_next = SHIFT;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and counter next-values. Outputs are registered, so x_next is
    // the bit that will be presented in the following cycle. At start the
    // raw inputs are used since the latched copies are not yet loaded.
    always_comb begin
        bit_idx_next = bit_idx;
        reps_next    = reps_left;
        x_next       = x;
        valid_next   = valid;
        busy_next    = busy;
        done_next    = 1'b0;
        pat_shift    = '0;
        unique case (state)
            IDLE: begin
                x_next     = 1'b0;
                valid_next = 1'b0;
                busy_next  = 1'b0;
                if (start) begin
                    bit_idx_next = len_norm - LW'(1);
                    reps_next    = repeat_cnt;
                    pat_shift    = pattern >> bit_idx_next;
                    x_next       = pat_shift[0];
                    valid_next   = 1'b1;
                    busy_next    = 1'b1;
                end
            end
            SHIFT: begin
                if (ready) begin
                    if (bit_idx != '0) begin
                        bit_idx_next = bit_idx - LW'(1);
                        pat_shift    = pat_q >> bit_idx_next;
                        x_next       = pat_shift[0];
                    end else begin
                        x_next     = 1'b0;
                        valid_next = 1'b0;
                        if (reps_left != '0) begin
                            reps_next = reps_left - RW'(1);
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                bit_idx_next = len_q - LW'(1);
                pat_shift    = pat_q >> bit_idx_next;
                x_next       = pat_shift[0];
                valid_next   = 1'b1;
            end
            DONE: begin
                x_next     = 1'b0;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
            default: begin
                x_next     = 1'b0;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
`ifdef PATGEN_PRBS_EN
        // The LFSR register MSB next cycle is exactly the bit to present.
        if (valid_next && prbs_active) x_next = lfsr_next[6];
`endif
    end

`ifdef PATGEN_PRBS_EN
    assign prbs_active = (state == IDLE) ? prbs_sel : prbs_q;

    // LFSR steps only on accepted bits, so stalls and gaps never skip bits.
    always_comb begin
        lfsr_next = lfsr;
        if (state == IDLE && start) begin
            lfsr_next = 7'h7F;
        end else if (state == SHIFT && ready) begin
            lfsr_next = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prbs_q <= 1'b0;
            lfsr   <= '0;
        end else begin
            lfsr <= lfsr_next;
            if (state == IDLE && start) prbs_q <= prbs_sel;
        end
    end
`endif

    // Datapath registers: latched configuration, counters and outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pat_q     <= '0;
            len_q     <= '0;
            bit_idx   <= '0;
            reps_left <= '0;
            x         <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                pat_q <= pattern;
                len_q <= len_norm;
            end
            bit_idx   <= bit_idx_next;
            reps_left <= reps_next;
            x         <= x_next;
            valid     <= valid_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_pattern_generator.sv
// ---------------------------------------------------------------------------
// tb_pattern_generator
//   Directed bench for pattern_generator. Each run is described by cycle-
//   indexed expected vectors for x and valid (bit c = cycle c after start
//   was sampled) plus the done cycle; busy is expected high on cycles
//   1..done. Bit 0 of every vector is unused.
// ---------------------------------------------------------------------------
module tb_pattern_generator;

    localparam int W  = 8;
    localparam int LW = 4;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic [W-1:0]  pattern = '0;
    logic [LW-1:0] len = '0;
    logic [RW-1:0] repeat_cnt = '0;
`ifdef PATGEN_PRBS_EN
    logic          prbs_sel = 1'b0;
`endif
    logic          x, valid, busy, done;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pattern_generator #(.W(W), .LW(LW), .RW(RW)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .repeat_cnt (repeat_cnt),
`ifdef PATGEN_PRBS_EN
        .prbs_sel   (prbs_sel),
`endif
        .ready      (ready),
        .x          (x),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    // Advance to just after the next active edge; inputs change and
    // outputs are sampled here, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Present configuration with start high for cycle 0.
    task automatic applyStimulus(input logic [W-1:0] pat, input logic [LW-1:0] ln,
                                 input logic [RW-1:0] rc);
        pattern    = pat;
        len        = ln;
        repeat_cnt = rc;
        ready      = 1'b1;
        start      = 1'b1;
        tick();
    endtask

    // One transmission, checking {x,valid,busy,done} on cycles 1..n+1.
    // rdy_low/st_mask are cycle-indexed; clr_pat zeroes pattern wherever
    // st_mask re-pulses start; abort_cycle asserts reset on that cycle.
    task automatic runCheck(input string tag, input logic [W-1:0] pat,
                            input logic [LW-1:0] ln, input logic [RW-1:0] rc,
                            input int n, input logic [31:0] ex, input logic [31:0] ev,
                            input logic [31:0] rdy_low, input logic [31:0] st_mask,
                            input logic clr_pat, input int abort_cycle);
        logic [3:0] exp_v;
        applyStimulus(pat, ln, rc);
        for (int c = 1; c <= n + 1; c++) begin
            start = st_mask[c];
            ready = !rdy_low[c];
            if (clr_pat && st_mask[c]) pattern = '0;
            if (c == abort_cycle) begin
                n_rst = 1'b0;
                #1;
                checkOutput($sformatf("%s abort", tag), {28'd0, x, valid, busy, done}, 32'd0);
                start = 1'b0;
                ready = 1'b1;
                return;
            end
            exp_v = {ex[c], ev[c], c <= n, c == n};
            checkOutput($sformatf("%s c%0d", tag, c), {28'd0, x, valid, busy, done},
                        {28'd0, exp_v});
            tick();
        end
        ready = 1'b1;
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("reset", {28'd0, x, valid, busy, done}, 32'd0);
        tick();
        n_rst = 1'b1;
        tick();
        checkOutput("post-reset idle", {28'd0, x, valid, busy, done}, 32'd0);

        // B2, len=0 -> 8 bits 1,0,1,1,0,0,1,0; done cycle 9
        runCheck("full", 8'hB2, 4'd0, 4'd0, 9, 32'h09A, 32'h1FE, 0, 0, 1'b0, 0);

        // len=3, two extra repeats: 010 gap 010 gap 010, done cycle 12
        runCheck("rep", 8'hB2, 4'd3, 4'd2, 12, 32'h444, 32'hEEE, 0, 0, 1'b0, 0);

        // ready low on cycles 3..5: third bit held through cycle 6
        runCheck("stall", 8'hB2, 4'd0, 4'd0, 12, 32'h4FA, 32'hFFE, 32'h38, 0, 1'b0, 0);

        // start re-pulsed and pattern cleared on cycle 4: ignored
        runCheck("restart", 8'hB2, 4'd0, 4'd0, 9, 32'h09A, 32'h1FE, 0, 32'h10, 1'b1, 0);

        // len=1, one extra repeat: 1 gap 1, done cycle 4
        runCheck("len1", 8'h01, 4'd1, 4'd1, 4, 32'h00A, 32'h00A, 0, 0, 1'b0, 0);

        // len=9 (>W) treated as W: 5A -> 0,1,0,1,1,0,1,0
        runCheck("len9", 8'h5A, 4'd9, 4'd0, 9, 32'h0B4, 32'h1FE, 0, 0, 1'b0, 0);

        // start held: 2-bit run, idle cycle 4, new run first bit on cycle 5
        runCheck("held", 8'h02, 4'd2, 4'd0, 3, 32'h002, 32'h006, 0, 32'hFFFF_FFFF, 1'b0, 0);
        checkOutput("held rerun", {29'd0, x, valid, busy}, 32'h7);
        start = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        checkOutput("held drain", {31'd0, busy}, 32'd0);
        tick();

        // Reset during cycle 5 aborts with no done pulse
        runCheck("abort", 8'hB2, 4'd0, 4'd0, 9, 32'h09A, 32'h1FE, 0, 0, 1'b0, 5);
        tick();
        checkOutput("abort hold", {28'd0, x, valid, busy, done}, 32'd0);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("abort no done %0d", i), {30'd0, busy, done}, 32'd0);
        end
        runCheck("after abort", 8'hB2, 4'd0, 4'd0, 9, 32'h09A, 32'h1FE, 0, 0, 1'b0, 0);

`ifdef PATGEN_PRBS_EN
        // PRBS7 from 7F: first seven MSBs are all ones; done cycle 8
        prbs_sel = 1'b1;
        runCheck("prbs", 8'h00, 4'd7, 4'd0, 8, 32'h0FE, 32'h0FE, 0, 0, 1'b0, 0);
        prbs_sel = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
